wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 91 +++++++++
 tb/tb_wb_regfile.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file with two registered read ports.
// R0 is hardwired to zero. Writes and reads share one rising clock edge.
// Build option: define WB_RF_BYPASS_EN to forward the value being written
// to a read port that addresses the same register in the same cycle
// (write-through). Without it, such a read returns the pre-write value.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_wrt,
    input  logic [ADDR_W-1:0] i_wb_dst,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic [DATA_W-1:0] o_wb_data
);

    localparam int NREG = 2 ** ADDR_W;

    // Only R1..R(NREG-1) hold state; R0 has no storage at all.
    logic [DATA_W-1:0] regs_q [1:NREG-1];

    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              wr_active;

    // Writeback value is selected combinationally, independent of the enable.
    assign o_wb_data = i_mem_to_reg ? i_mem_data : i_alu_result;

    // A write to R0 is never an effective write.
    assign wr_active = i_reg_wrt && (i_wb_dst != '0);

    // One storage register per nonzero address; reset wins over a write.
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (wr_active && (i_wb_dst == ADDR_W'(gi))) begin
                    regs_q[gi] <= o_wb_data;
                end
            end
        end
    endgenerate

    // Resolve the value one read port would capture at this edge.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != '0) begin
`ifdef WB_RF_BYPASS_EN
            if (wr_active && (addr == i_wb_dst)) begin
                val = o_wb_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    // Next-state values for both read ports, resolved independently.
    always_comb begin
        rd_data1_d = read_value(i_rd_addr1);
        rd_data2_d = read_value(i_rd_addr2);
    end

    // Read-port registers: cleared by reset, updated only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else if (i_rd_en) begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign o_rd_data1 = rd_data1_q;
    assign o_rd_data2 = rd_data2_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile (default 16-bit data, 16 registers).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_to_reg;
    logic        i_reg_wrt;
    logic [3:0]  i_wb_dst;
    logic [15:0] i_mem_data;
    logic [15:0] i_alu_result;
    logic        i_rd_en;
    logic [3:0]  i_rd_addr1;
    logic [3:0]  i_rd_addr2;
    logic [15:0] o_rd_data1;
    logic [15:0] o_rd_data2;
    logic [15:0] o_wb_data;

    int tests_run = 0;
    int tests_failed = 0;

    wb_regfile #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_to_reg (i_mem_to_reg),
        .i_reg_wrt    (i_reg_wrt),
        .i_wb_dst     (i_wb_dst),
        .i_mem_data   (i_mem_data),
        .i_alu_result (i_alu_result),
        .i_rd_en      (i_rd_en),
        .i_rd_addr1   (i_rd_addr1),
        .i_rd_addr2   (i_rd_addr2),
        .o_rd_data1   (o_rd_data1),
        .o_rd_data2   (o_rd_data2),
        .o_wb_data    (o_wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bypass_exp;

    initial begin
        rst = 1'b1; i_mem_to_reg = 1'b0; i_reg_wrt = 1'b0; i_wb_dst = 4'd0;
        i_mem_data = 16'h0; i_alu_result = 16'h0; i_rd_en = 1'b0;
        i_rd_addr1 = 4'd0; i_rd_addr2 = 4'd0;

        // One cycle of reset clears the read ports.
        tick();
        check("reset_rd1", o_rd_data1, 16'h0000);
        check("reset_rd2", o_rd_data2, 16'h0000);
        rst = 1'b0;

        // Every register reads back zero after reset.
        i_rd_en = 1'b1;
        for (int a = 1; a < 16; a++) begin
            i_rd_addr1 = 4'(a);
            i_rd_addr2 = 4'(16 - a);
            tick();
            check($sformatf("reset_R%0d", a), o_rd_data1, 16'h0000);
            check($sformatf("reset_R%0d_p2", 16 - a), o_rd_data2, 16'h0000);
        end

        // Writeback mux is combinational and ignores the write enable.
        i_rd_en = 1'b0; i_alu_result = 16'h1234; i_mem_data = 16'hBEEF;
        i_mem_to_reg = 1'b0; #1;
        check("wb_sel_alu", o_wb_data, 16'h1234);
        i_mem_to_reg = 1'b1; #1;
        check("wb_sel_mem", o_wb_data, 16'hBEEF);

        // Write R5 from the ALU path, R6 from the memory path.
        i_reg_wrt = 1'b1; i_wb_dst = 4'd5; i_mem_to_reg = 1'b0;
        tick();
        i_wb_dst = 4'd6; i_mem_to_reg = 1'b1;
        tick();
        i_reg_wrt = 1'b0; i_rd_en = 1'b1; i_rd_addr1 = 4'd5; i_rd_addr2 = 4'd5;
        tick();
        check("R5_p1", o_rd_data1, 16'h1234);
        check("R5_p2", o_rd_data2, 16'h1234);
        i_rd_addr1 = 4'd6; i_rd_addr2 = 4'd5;
        tick();
        check("R6_p1", o_rd_data1, 16'hBEEF);
        check("R5_p2_indep", o_rd_data2, 16'h1234);

        // Writes to R0 are dropped, even when read in the same cycle.
        i_reg_wrt = 1'b1; i_wb_dst = 4'd0; i_mem_to_reg = 1'b0; i_alu_result = 16'hFFFF;
        i_rd_addr1 = 4'd0; i_rd_addr2 = 4'd0;
        tick();
        check("R0_sameclk_p1", o_rd_data1, 16'h0000);
        check("R0_sameclk_p2", o_rd_data2, 16'h0000);
        i_reg_wrt = 1'b0;
        tick();
        check("R0_p1", o_rd_data1, 16'h0000);
        check("R0_p2", o_rd_data2, 16'h0000);

        // Same-cycle read/write of R3.
        i_rd_en = 1'b0; i_reg_wrt = 1'b1; i_wb_dst = 4'd3; i_alu_result = 16'h0001;
        tick();
        i_alu_result = 16'h00AA; i_rd_en = 1'b1; i_rd_addr1 = 4'd3; i_rd_addr2 = 4'd3;
`ifdef WB_RF_BYPASS_EN
        bypass_exp = 16'h00AA;
`else
        bypass_exp = 16'h0001;
`endif
        tick();
        check("R3_rw_p1", o_rd_data1, bypass_exp);
        check("R3_rw_p2", o_rd_data2, bypass_exp);
        i_reg_wrt = 1'b0;
        tick();
        check("R3_after_p1", o_rd_data1, 16'h00AA);

        // Read ports hold while disabled, even as the addressed register changes.
        i_rd_en = 1'b0; i_reg_wrt = 1'b1; i_wb_dst = 4'd7; i_alu_result = 16'h5555;
        i_rd_addr1 = 4'd7; i_rd_addr2 = 4'd7;
        tick();
        check("hold_p1", o_rd_data1, 16'h00AA);
        check("hold_p2", o_rd_data2, 16'h00AA);
        i_reg_wrt = 1'b0; i_rd_en = 1'b1;
        tick();
        check("R7_p1", o_rd_data1, 16'h5555);
        check("R7_p2", o_rd_data2, 16'h5555);

        // Reset raised mid-cycle must wait for the edge, then beat write and read.
        rst = 1'b1; i_reg_wrt = 1'b1; i_wb_dst = 4'd2; i_alu_result = 16'h7777;
        #2;
        check("sync_rst_p1", o_rd_data1, 16'h5555);
        @(posedge clk); #1;
        check("rst_prio_p1", o_rd_data1, 16'h0000);
        check("rst_prio_p2", o_rd_data2, 16'h0000);
        rst = 1'b0; i_reg_wrt = 1'b0; i_rd_addr1 = 4'd2; i_rd_addr2 = 4'd7;
        tick();
        check("R2_after_rst", o_rd_data1, 16'h0000);
        check("R7_after_rst", o_rd_data2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
